if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage ARM pipeline; feeds the IF/ID pipeline register directly.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Buffers one fetched instruction and holds it under freeze.
- Applies EXE-stage branch redirects, discarding wrong-path fetches, including one still in flight.

---
 rtl/if_fetch_stage.sv | 106 ++++++++++
 tb/tb_if_fetch_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// buffers one instruction for IF/ID and applies EXE-stage branch redirects.
module if_fetch_stage #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               fetch_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instruction_out
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]         state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [ADDR_W-1:0]  req_addr, req_addr_n;
  logic [ADDR_W-1:0]  seq_addr;
  logic [INSTR_W-1:0] buf_instr;
  logic [ADDR_W-1:0]  buf_pc;
  logic               buf_valid;
  logic               buf_load, buf_clr;
  logic               handshake;

  // Gating with rst drops the request immediately on reset and lets the first
  // request appear in the very first cycle after release.
  assign imem_req        = ~rst & (state != HOLD);
  assign imem_addr       = req_addr;
  assign handshake       = imem_req & imem_ack;
  assign seq_addr        = req_addr + ADDR_W'(PC_STEP);
  assign fetch_valid     = buf_valid;
  assign pc_out          = buf_valid ? buf_pc : '0;
  assign instruction_out = buf_valid ? buf_instr : '0;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    buf_load   = 1'b0;
    buf_clr    = 1'b0;
    case (state)
      FETCH: begin
        if (handshake && !branch_taken) begin
          buf_load = 1'b1;
          pc_n     = seq_addr;
          state_n  = HOLD;
        end else if (branch_taken) begin
          pc_n = branch_addr;
          if (handshake) req_addr_n = branch_addr;
          else           state_n    = DRAIN;
        end
      end
      DRAIN: begin
        if (branch_taken) pc_n = branch_addr;
        if (handshake) begin
          state_n    = FETCH;
          req_addr_n = pc_n;
        end
      end
      HOLD: begin
        if (branch_taken) pc_n = branch_addr;
        if (branch_taken || !freeze) begin
          buf_clr    = 1'b1;
          state_n    = FETCH;
          req_addr_n = pc_n;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_instr <= '0;
      buf_pc    <= '0;
      buf_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      if (buf_load) begin
        buf_instr <= imem_rdata;
        buf_pc    <= seq_addr;
        buf_valid <= 1'b1;
      end else if (buf_clr) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs driven and outputs sampled on the
// falling edge, with expected addresses and data written out by hand.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;

  int tests = 0;
  int fails = 0;

  if_fetch_stage #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0),
    .PC_STEP (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .fetch_valid    (fetch_valid),
    .pc_out         (pc_out),
    .instruction_out(instruction_out)
  );

  always #5 clk = ~clk;

  // One request served with ack in its lat-th cycle; ends sampling the HOLD cycle.
  task automatic do_fetch(input logic [31:0] exp_addr, input int lat, input logic [31:0] data);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        fails++;
        $display("FAIL req_addr cyc%0d: req=%b addr=%h, expected req=1 addr=%h", i, imem_req, imem_addr, exp_addr);
      end
      tests++;
      if (fetch_valid !== 1'b0 || instruction_out !== 32'h0) begin
        fails++;
        $display("FAIL wait_nop: valid=%b instr=%h, expected 0/0", fetch_valid, instruction_out);
      end
      imem_ack   = (i == lat - 1);
      imem_rdata = (i == lat - 1) ? data : 32'hBAD0_BAD0;
    end
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    tests++;
    if (fetch_valid !== 1'b1 || pc_out !== exp_addr + 32'd4 || instruction_out !== data || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL hold: valid=%b pc=%h instr=%h req=%b, expected 1 %h %h 0",
               fetch_valid, pc_out, instruction_out, imem_req, exp_addr + 32'd4, data);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h, expected all 0", imem_req, fetch_valid, pc_out, instruction_out);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential;
    do_fetch(32'h0, 2, 32'hE000_0000);
    do_fetch(32'h4, 2, 32'hE000_0004);
    do_fetch(32'h8, 2, 32'hE000_0008);
  endtask

  task automatic test_latency;
    do_fetch(32'hC,  1, 32'hA1A1_0001);
    do_fetch(32'h10, 3, 32'hA1A1_0003);
    do_fetch(32'h14, 5, 32'hA1A1_0005);
  endtask

  task automatic test_freeze;
    do_fetch(32'h18, 1, 32'hF00D_0018);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (fetch_valid !== 1'b1 || pc_out !== 32'h1C || instruction_out !== 32'hF00D_0018 || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL freeze_hold cyc%0d: valid=%b pc=%h instr=%h req=%b, expected 1 0000001c f00d0018 0",
                 i, fetch_valid, pc_out, instruction_out, imem_req);
      end
    end
    freeze = 1'b0;
    do_fetch(32'h1C, 1, 32'hF00D_001C);
  endtask

  task automatic test_branch_pending;
    @(negedge clk);
    tests++;
    if (imem_addr !== 32'h20) begin
      fails++;
      $display("FAIL br_pend_pre: addr=%h, expected 00000020", imem_addr);
    end
    branch_taken = 1'b1; branch_addr = 32'h100;
    @(negedge clk);
    branch_addr = 32'h200;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_addr: req=%b addr=%h valid=%b, expected 1 00000020 0", imem_req, imem_addr, fetch_valid);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0020;
    tests++;
    if (imem_addr !== 32'h20) begin
      fails++;
      $display("FAIL drain_stable: addr=%h, expected 00000020", imem_addr);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    tests++;
    if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      fails++;
      $display("FAIL drain_redirect: valid=%b req=%b addr=%h, expected 0 1 00000200", fetch_valid, imem_req, imem_addr);
    end
    do_fetch(32'h200, 2, 32'h1234_0200);
  endtask

  task automatic test_branch_ack;
    @(negedge clk);
    branch_taken = 1'b1; branch_addr = 32'h300;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_0204;
    @(negedge clk);
    branch_taken = 1'b0; imem_ack = 1'b0;
    tests++;
    if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      fails++;
      $display("FAIL br_ack: valid=%b req=%b addr=%h, expected 0 1 00000300", fetch_valid, imem_req, imem_addr);
    end
    do_fetch(32'h300, 1, 32'h5555_0300);
    freeze = 1'b1;
    branch_taken = 1'b1; branch_addr = 32'h400;
    @(negedge clk);
    branch_taken = 1'b0;
    tests++;
    if (fetch_valid !== 1'b0 || instruction_out !== 32'h0 || pc_out !== 32'h0 || imem_addr !== 32'h400) begin
      fails++;
      $display("FAIL br_freeze: valid=%b instr=%h pc=%h addr=%h, expected 0 0 0 00000400",
               fetch_valid, instruction_out, pc_out, imem_addr);
    end
    do_fetch(32'h400, 1, 32'h6666_0400);
    freeze = 1'b0;
  endtask

  task automatic test_wrap;
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_taken = 1'b0;
    do_fetch(32'hFFFF_FFFC, 1, 32'h7777_FFFC);
    do_fetch(32'h0, 1, 32'h7777_0000);
  endtask

  task automatic test_reset_mid;
    do_fetch(32'h4, 1, 32'h8888_0004);
    freeze = 1'b1;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (fetch_valid !== 1'b0 || instruction_out !== 32'h0 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_hold: valid=%b instr=%h req=%b, expected 0 0 0", fetch_valid, instruction_out, imem_req);
    end
    @(negedge clk);
    rst = 1'b0; freeze = 1'b0;
    do_fetch(32'h0, 2, 32'h9999_0000);
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      fails++;
      $display("FAIL pre_rst_req: req=%b addr=%h, expected 1 00000004", imem_req, imem_addr);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_req: req=%b valid=%b, expected 0 0", imem_req, fetch_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_restart: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    do_fetch(32'h0, 1, 32'hAAAA_0000);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_freeze();
    test_branch_pending();
    test_branch_ack();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
